// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the LC-3b pipeline stall controller.
package pipe_stall_ctrl_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    CTL_RUN,
    CTL_DSTALL,
    CTL_ISTALL
  } ctl_state_t;

  localparam lc3b_word NOP_IR = 16'h0000;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-detector / memory handshake bundle and pipeline-register controls.
interface pipe_stall_ctrl_if;
  logic gen_bubble;
  logic squash_ID;
  logic imem_resp;
  logic dmem_req;
  logic dmem_resp;
  logic load_pc;
  logic load_if_id;
  logic nop_if_id;
  logic load_id_ex;
  logic nop_id_ex;
  logic load_ex_mem;
  logic load_mem_wb;
  logic nop_mem_wb;

  // master: hazard detector and memory side; slave: the stall controller
  modport master (
    output gen_bubble, squash_ID, imem_resp, dmem_req, dmem_resp,
    input  load_pc, load_if_id, nop_if_id, load_id_ex, nop_id_ex,
           load_ex_mem, load_mem_wb, nop_mem_wb
  );

  modport slave (
    input  gen_bubble, squash_ID, imem_resp, dmem_req, dmem_resp,
    output load_pc, load_if_id, nop_if_id, load_id_ex, nop_id_ex,
           load_ex_mem, load_mem_wb, nop_mem_wb
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_d;

  always_comb begin
    count_d = count;
    if (inc && (count != {width{1'b1}})) begin
      count_d = count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/bubble/squash controller for the 5-stage LC-3b, with stall and bubble counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stall_ctrl_if.slave ctl,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  ctl_state_t state_q, state_d;
  logic       pend_squash_q, pend_squash_d;
  logic       d_stall, i_stall, squash;
  logic       load_pc, load_if_id, nop_if_id, load_id_ex, nop_id_ex;
  logic       load_ex_mem, load_mem_wb, nop_mem_wb;
  logic       stall_inc, bubble_inc;

  always_comb begin
    // Once in DSTALL the MEM instruction is held, so only the response matters.
    if (state_q == CTL_DSTALL) begin
      d_stall = !ctl.dmem_resp;
    end else begin
      d_stall = ctl.dmem_req && !ctl.dmem_resp;
    end
    i_stall = !d_stall && !ctl.imem_resp;
    squash  = ctl.squash_ID || pend_squash_q;

    state_d = state_q;
    case (state_q)
      CTL_RUN: begin
        if (d_stall) begin
          state_d = CTL_DSTALL;
        end else if (i_stall) begin
          state_d = CTL_ISTALL;
        end
      end
      CTL_DSTALL: begin
        if (ctl.dmem_resp) begin
          state_d = CTL_RUN;
        end
      end
      CTL_ISTALL: begin
        if (d_stall) begin
          state_d = CTL_DSTALL;
        end else if (ctl.imem_resp) begin
          state_d = CTL_RUN;
        end
      end
      default: state_d = CTL_RUN;
    endcase

    pend_squash_d = d_stall && squash;

    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    nop_if_id   = 1'b0;
    load_id_ex  = 1'b0;
    nop_id_ex   = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    nop_mem_wb  = 1'b0;
    stall_inc   = 1'b0;
    if (reset) begin
      stall_inc = 1'b0;
    end else if (d_stall) begin
      load_mem_wb = 1'b1;
      nop_mem_wb  = 1'b1;
      stall_inc   = 1'b1;
    end else if (i_stall) begin
      load_if_id  = 1'b1;
      nop_if_id   = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      stall_inc   = 1'b1;
    end else begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      nop_id_ex   = ctl.gen_bubble;
      // A squash replaces IF/ID anyway, so the bubble need not hold PC or IF/ID.
      if (ctl.gen_bubble && !squash) begin
        load_pc    = 1'b0;
        load_if_id = 1'b0;
      end
      nop_if_id = squash;
    end
    bubble_inc = nop_id_ex;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CTL_RUN;
      pend_squash_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_squash_q <= pend_squash_d;
    end
  end

  assign ctl.load_pc     = load_pc;
  assign ctl.load_if_id  = load_if_id;
  assign ctl.nop_if_id   = nop_if_id;
  assign ctl.load_id_ex  = load_id_ex;
  assign ctl.nop_id_ex   = nop_id_ex;
  assign ctl.load_ex_mem = load_ex_mem;
  assign ctl.load_mem_wb = load_mem_wb;
  assign ctl.nop_mem_wb  = nop_mem_wb;

  sat_counter #(
    .width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(
    .width(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (bubble_inc),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed, table-driven bench for pipe_stall_ctrl (4-bit counters to reach saturation).
module tb_pipe_stall_ctrl;

  localparam int unsigned CW = 4;

  // Output vector: {load_pc, load_if_id, nop_if_id, load_id_ex, nop_id_ex,
  //                 load_ex_mem, load_mem_wb, nop_mem_wb}
  localparam logic [7:0] O_FREE   = 8'hD6;
  localparam logic [7:0] O_BUBBLE = 8'h1E;
  localparam logic [7:0] O_DSTALL = 8'h03;
  localparam logic [7:0] O_ISTALL = 8'h76;
  localparam logic [7:0] O_SQUASH = 8'hF6;
  localparam logic [7:0] O_SQ_BUB = 8'hFE;
  localparam logic [7:0] O_NONE   = 8'h00;

  typedef struct {
    logic [4:0] in;   // {gen_bubble, squash_ID, imem_resp, dmem_req, dmem_resp}
    logic [7:0] exp;
  } vec_t;

  logic          clk;
  logic          reset;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
  int            checks;
  int            errors;
  vec_t          vecs[15];

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ctl       (bus.slave),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.load_pc, bus.load_if_id, bus.nop_if_id, bus.load_id_ex, bus.nop_id_ex,
            bus.load_ex_mem, bus.load_mem_wb, bus.nop_mem_wb};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {bus.gen_bubble, bus.squash_ID, bus.imem_resp, bus.dmem_req, bus.dmem_resp} = in;
  endtask

  // Called at posedge+1: drive, check outputs before the edge, advance to next posedge+1.
  task automatic step(input string name, input logic [4:0] in, input logic [7:0] exp);
    drive(in);
    #4;
    check(name, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #4;
    check("reset_outs", outs(), O_NONE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_stall_cnt", 8'(stall_cnt), 8'h0);
    check("reset_bubble_cnt", 8'(bubble_cnt), 8'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(5'b00100);

    vecs[0]  = '{5'b00100, O_FREE};
    vecs[1]  = '{5'b10100, O_BUBBLE};
    vecs[2]  = '{5'b01100, O_SQUASH};
    vecs[3]  = '{5'b11100, O_SQ_BUB};
    vecs[4]  = '{5'b00000, O_ISTALL};
    vecs[5]  = '{5'b00000, O_ISTALL};
    vecs[6]  = '{5'b00100, O_FREE};
    vecs[7]  = '{5'b00111, O_FREE};    // request and response together: no stall
    vecs[8]  = '{5'b00110, O_DSTALL};
    vecs[9]  = '{5'b00010, O_DSTALL};  // D-stall dominates I-stall
    vecs[10] = '{5'b10110, O_DSTALL};  // bubble dropped while frozen
    vecs[11] = '{5'b00111, O_FREE};
    vecs[12] = '{5'b00000, O_ISTALL};
    vecs[13] = '{5'b00010, O_DSTALL};  // ISTALL -> DSTALL
    vecs[14] = '{5'b00111, O_FREE};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      step("free_run", 5'b00100, O_FREE);
    end
    check("free_stall_cnt", 8'(stall_cnt), 8'h0);
    check("free_bubble_cnt", 8'(bubble_cnt), 8'h0);

    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
    end
    check("table_stall_cnt", 8'(stall_cnt), 8'd7);
    check("table_bubble_cnt", 8'(bubble_cnt), 8'd2);

    // Three-cycle D-stall from a clean start.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step("dstall_frozen", 5'b00110, O_DSTALL);
    end
    step("dstall_resp", 5'b00111, O_FREE);
    check("dstall_stall_cnt", 8'(stall_cnt), 8'd3);

    // Squash during a D-stall is deferred to the first free cycle only.
    step("sq_stall1", 5'b01110, O_DSTALL);
    step("sq_stall2", 5'b00110, O_DSTALL);
    step("sq_resp", 5'b00111, O_SQUASH);
    step("sq_after", 5'b00100, O_FREE);

    // Reset in DSTALL with a squash pending.
    step("rst_enter", 5'b01110, O_DSTALL);
    drive(5'b00110);
    #2;
    reset = 1'b1;
    #2;
    check("rst_in_dstall", outs(), O_NONE);
    @(posedge clk);
    #1;
    check("rst_held", outs(), O_NONE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("rst_release", 5'b00100, O_FREE);
    check("rst_stall_cnt", 8'(stall_cnt), 8'h0);

    // Saturation: 20 stall cycles on a 4-bit counter.
    for (int i = 0; i < 15; i++) begin
      step("sat_fill", 5'b00110, O_DSTALL);
    end
    check("sat_reach", 8'(stall_cnt), 8'h0F);
    for (int i = 0; i < 5; i++) begin
      step("sat_hold", 5'b00010, O_DSTALL);
    end
    check("sat_stay", 8'(stall_cnt), 8'h0F);
    step("sat_exit", 5'b00111, O_FREE);
    check("sat_final", 8'(stall_cnt), 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
